// File: rtl/sprite_blitter.sv
// Multi-channel sprite blitter: per frame, erases each enabled sprite at its
// previous cell and redraws it at the new cell through a registered pixel port.
module sprite_blitter #(
    parameter int N           = 4,
    parameter int SW          = 5,
    parameter int SH          = 5,
    parameter int CELL        = 5,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int TRANSPARENT = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [N-1:0]      ch_en,
    input  logic [N*XW-1:0]   x_cell,
    input  logic [N*YW-1:0]   y_cell,
    input  logic [N*SW*SH-1:0] shape,
    input  logic [N*3-1:0]    colour,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [2:0]        col_out,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam int NPIX = SW * SH;
    localparam int CHW  = (N > 1) ? $clog2(N) : 1;
    localparam int CXW  = (SW > 1) ? $clog2(SW) : 1;
    localparam int CYW  = (SH > 1) ? $clog2(SH) : 1;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ERASE,
        DRAW,
        NEXT,
        DONE
    } state_t;

    state_t          state;
    logic [CHW-1:0]  ch;
    logic [CHW-1:0]  nxt_ch;
    logic            nxt_found;
    logic [CXW-1:0]  col_cnt;
    logic [CYW-1:0]  row_cnt;
    logic [N-1:0]    pending;
    logic [N-1:0]    prev_valid;

    logic [XW-1:0]   lat_x [N];
    logic [YW-1:0]   lat_y [N];
    logic [NPIX-1:0] lat_shape [N];
    logic [2:0]      lat_col [N];
    logic [XW-1:0]   prev_x [N];
    logic [YW-1:0]   prev_y [N];

    logic            erasing;
    logic [XW-1:0]   base_xc;
    logic [YW-1:0]   base_yc;
    logic [XW-1:0]   x_px;
    logic [YW-1:0]   y_px;
    logic [PW-1:0]   pix_idx;
    logic            pix_on;
    logic            col_last;
    logic            row_last;

    assign busy = (state != IDLE);

    // Lowest still-pending channel; pending bits clear as each channel finishes.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                nxt_found = 1'b1;
                nxt_ch    = CHW'(i);
            end
        end
    end

    always_comb begin
        erasing  = (state == ERASE);
        base_xc  = erasing ? prev_x[ch] : lat_x[ch];
        base_yc  = erasing ? prev_y[ch] : lat_y[ch];
        x_px     = base_xc * XW'(CELL) + XW'(col_cnt);
        y_px     = base_yc * YW'(CELL) + YW'(row_cnt);
        pix_idx  = PW'(NPIX - 1)
                 - (PW'(row_cnt) * PW'(SW) + PW'(col_cnt));
        pix_on   = lat_shape[ch][pix_idx];
        col_last = (col_cnt == CXW'(SW - 1));
        row_last = (row_cnt == CYW'(SH - 1));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            ch         <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            pending    <= '0;
            prev_valid <= '0;
            x          <= '0;
            y          <= '0;
            col_out    <= '0;
            plot       <= 1'b0;
            done       <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start)
                        state <= LOAD;
                end
                LOAD: begin
                    pending <= ch_en;
                    state   <= NEXT;
                end
                NEXT: begin
                    if (nxt_found) begin
                        ch      <= nxt_ch;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        state   <= prev_valid[nxt_ch] ? ERASE : DRAW;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                ERASE, DRAW: begin
                    x       <= x_px;
                    y       <= y_px;
                    plot    <= erasing | pix_on | (TRANSPARENT == 0);
                    col_out <= (!erasing && pix_on) ? lat_col[ch] : 3'b000;
                    if (!col_last) begin
                        col_cnt <= col_cnt + 1'b1;
                    end else begin
                        col_cnt <= '0;
                        if (!row_last) begin
                            row_cnt <= row_cnt + 1'b1;
                        end else begin
                            row_cnt <= '0;
                            if (erasing) begin
                                state <= DRAW;
                            end else begin
                                prev_valid[ch] <= 1'b1;
                                pending[ch]    <= 1'b0;
                                state          <= NEXT;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Frame snapshot and previous-position store; validity lives in prev_valid.
    always_ff @(posedge clock) begin
        if (state == LOAD) begin
            for (int i = 0; i < N; i++) begin
                lat_x[i]     <= x_cell[i*XW +: XW];
                lat_y[i]     <= y_cell[i*YW +: YW];
                lat_shape[i] <= shape[i*NPIX +: NPIX];
                lat_col[i]   <= colour[i*3 +: 3];
            end
        end
        if (state == DRAW && col_last && row_last) begin
            prev_x[ch] <= lat_x[ch];
            prev_y[ch] <= lat_y[ch];
        end
    end

endmodule
